// File: rtl/jtbubl_rom_sched_if.sv
// rtl/jtbubl_rom_sched_if.sv - CPU ROM slot buses and SDRAM read port of the ROM scheduler
interface jtbubl_rom_sched_if #(
  parameter int SLOT0_AW = 18,
  parameter int SLOT1_AW = 15,
  parameter int SLOT2_AW = 12,
  parameter int SLOT3_AW = 15
);
  logic                slot0_cs;
  logic [SLOT0_AW-1:0] slot0_addr;
  logic                slot0_ok;
  logic [7:0]          slot0_dout;
  logic                slot1_cs;
  logic [SLOT1_AW-1:0] slot1_addr;
  logic                slot1_ok;
  logic [7:0]          slot1_dout;
  logic                slot2_cs;
  logic [SLOT2_AW-1:0] slot2_addr;
  logic                slot2_ok;
  logic [7:0]          slot2_dout;
  logic                slot3_cs;
  logic [SLOT3_AW-1:0] slot3_addr;
  logic                slot3_ok;
  logic [7:0]          slot3_dout;
  logic                sdram_req;
  logic [21:0]         sdram_addr;
  logic                sdram_ack;
  logic                data_rdy;
  logic [31:0]         data_read;
  logic                refresh_en;

  modport slave (
    input  slot0_cs, slot0_addr, slot1_cs, slot1_addr,
    input  slot2_cs, slot2_addr, slot3_cs, slot3_addr,
    input  sdram_ack, data_rdy, data_read,
    output slot0_ok, slot0_dout, slot1_ok, slot1_dout,
    output slot2_ok, slot2_dout, slot3_ok, slot3_dout,
    output sdram_req, sdram_addr, refresh_en
  );

  modport master (
    output slot0_cs, slot0_addr, slot1_cs, slot1_addr,
    output slot2_cs, slot2_addr, slot3_cs, slot3_addr,
    output sdram_ack, data_rdy, data_read,
    input  slot0_ok, slot0_dout, slot1_ok, slot1_dout,
    input  slot2_ok, slot2_dout, slot3_ok, slot3_dout,
    input  sdram_req, sdram_addr, refresh_en
  );
endinterface

// File: rtl/jtbubl_rom_sched.sv
// rtl/jtbubl_rom_sched.sv - four-slot CPU ROM fetch scheduler with one-line caches onto one SDRAM read port
module jtbubl_rom_sched #(
  parameter int          SLOT0_AW     = 18,
  parameter int          SLOT1_AW     = 15,
  parameter int          SLOT2_AW     = 12,
  parameter int          SLOT3_AW     = 15,
  parameter logic [21:0] SLOT0_OFFSET = 22'h0,
  parameter logic [21:0] SLOT1_OFFSET = 22'h0,
  parameter logic [21:0] SLOT2_OFFSET = 22'h0,
  parameter logic [21:0] SLOT3_OFFSET = 22'h0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              downloading,
  jtbubl_rom_sched_if.slave bus
);
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXAW = max2(max2(SLOT0_AW, SLOT1_AW), max2(SLOT2_AW, SLOT3_AW));
  localparam int TW    = MAXAW - 2;

  function automatic logic [21:0] slot_off(input logic [1:0] s);
    case (s)
      2'd0:    return SLOT0_OFFSET;
      2'd1:    return SLOT1_OFFSET;
      2'd2:    return SLOT2_OFFSET;
      default: return SLOT3_OFFSET;
    endcase
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      grant_q, grant_d;
  logic [TW-1:0]   tag_lat_q, tag_lat_d;
  logic [21:0]     addr_q, addr_d;
  logic            req_q, req_d;
  logic [31:0]     data_q [4];
  logic [31:0]     data_d [4];
  logic [TW-1:0]   tag_q [4];
  logic [TW-1:0]   tag_d [4];
  logic [3:0]      valid_q, valid_d;

  // Narrower slots are zero-extended so all tags compare at a common width.
  logic [MAXAW-1:0] addr_x [4];
  logic [3:0]       cs, hit, ok, miss;
  logic [7:0]       dout [4];
  logic             found;
  logic [1:0]       sel, idx;

  always_comb begin
    addr_x[0] = MAXAW'(bus.slot0_addr);
    addr_x[1] = MAXAW'(bus.slot1_addr);
    addr_x[2] = MAXAW'(bus.slot2_addr);
    addr_x[3] = MAXAW'(bus.slot3_addr);
    cs = {bus.slot3_cs, bus.slot2_cs, bus.slot1_cs, bus.slot0_cs};
    for (int i = 0; i < 4; i++) begin
      hit[i]  = cs[i] & valid_q[i] & (tag_q[i] == addr_x[i][MAXAW-1:2]);
      ok[i]   = hit[i] & ~downloading;
      miss[i] = cs[i] & ~hit[i];
      dout[i] = ok[i] ? data_q[i][{addr_x[i][1:0], 3'b000} +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    tag_lat_d = tag_lat_q;
    addr_d    = addr_q;
    req_d     = req_q;
    data_d    = data_q;
    tag_d     = tag_q;
    valid_d   = downloading ? 4'b0000 : valid_q;
    found     = 1'b0;
    sel       = 2'd0;
    idx       = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (|miss && !downloading) begin
          // Round-robin: scan starting just after the previous grant.
          for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && miss[idx]) begin
              found = 1'b1;
              sel   = idx;
            end
          end
          grant_d   = sel;
          last_d    = sel;
          tag_lat_d = addr_x[sel][MAXAW-1:2];
          addr_d    = slot_off(sel) + 22'({addr_x[sel][MAXAW-1:2], 1'b0});
          req_d     = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (downloading) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (bus.sdram_ack) begin
          req_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.data_rdy) begin
          state_d = ST_IDLE;
          if (!downloading) begin
            data_d[grant_q]  = bus.data_read;
            tag_d[grant_q]   = tag_lat_q;
            valid_d[grant_q] = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      last_q    <= 2'd3;
      grant_q   <= 2'd0;
      tag_lat_q <= '0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      valid_q   <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      tag_lat_q <= tag_lat_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
    end
  end

  assign bus.slot0_ok   = ok[0];
  assign bus.slot1_ok   = ok[1];
  assign bus.slot2_ok   = ok[2];
  assign bus.slot3_ok   = ok[3];
  assign bus.slot0_dout = dout[0];
  assign bus.slot1_dout = dout[1];
  assign bus.slot2_dout = dout[2];
  assign bus.slot3_dout = dout[3];
  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;
  // Held low in reset so every output reads 0 while rstn is asserted.
  assign bus.refresh_en = rstn & (((state_q == ST_IDLE) & ~|miss) | downloading);
endmodule

// File: tb/tb_jtbubl_rom_sched.sv
// tb/tb_jtbubl_rom_sched.sv - directed bench with a cache/arbiter reference model for jtbubl_rom_sched
module tb_jtbubl_rom_sched;
  localparam logic [21:0] OFF0 = 22'h0;
  localparam logic [21:0] OFF1 = 22'h14000;
  localparam logic [21:0] OFF2 = 22'h20000;
  localparam logic [21:0] OFF3 = 22'h3FFFFF;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic downloading = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  jtbubl_rom_sched_if #(.SLOT0_AW(18), .SLOT1_AW(15), .SLOT2_AW(12), .SLOT3_AW(15)) bus ();

  jtbubl_rom_sched #(
    .SLOT0_AW(18), .SLOT1_AW(15), .SLOT2_AW(12), .SLOT3_AW(15),
    .SLOT0_OFFSET(OFF0), .SLOT1_OFFSET(OFF1), .SLOT2_OFFSET(OFF2), .SLOT3_OFFSET(OFF3)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .downloading(downloading),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int s_addr(input int s);
    case (s)
      0: return int'(bus.slot0_addr);
      1: return int'(bus.slot1_addr);
      2: return int'(bus.slot2_addr);
      default: return int'(bus.slot3_addr);
    endcase
  endfunction

  function automatic bit s_cs(input int s);
    case (s)
      0: return bus.slot0_cs;
      1: return bus.slot1_cs;
      2: return bus.slot2_cs;
      default: return bus.slot3_cs;
    endcase
  endfunction

  function automatic logic [8:0] s_out(input int s);
    case (s)
      0: return {bus.slot0_ok, bus.slot0_dout};
      1: return {bus.slot1_ok, bus.slot1_dout};
      2: return {bus.slot2_ok, bus.slot2_dout};
      default: return {bus.slot3_ok, bus.slot3_dout};
    endcase
  endfunction

  function automatic int s_off(input int s);
    case (s)
      0: return int'(OFF0);
      1: return int'(OFF1);
      2: return int'(OFF2);
      default: return int'(OFF3);
    endcase
  endfunction

  // Reference model: each slot caches one 4-byte line; busy 0=free, 1=requesting, 2=awaiting data.
  bit          m_valid [4];
  int          m_line  [4];
  logic [31:0] m_data  [4];
  int          m_busy, m_slot, m_lat, m_last;

  function automatic bit m_hit(input int s);
    return s_cs(s) && m_valid[s] && (m_line[s] == (s_addr(s) >> 2));
  endfunction

  function automatic bit m_miss(input int s);
    return s_cs(s) && !m_hit(s);
  endfunction

  function automatic int m_pick();
    for (int k = 1; k <= 4; k++)
      if (m_miss((m_last + k) % 4)) return (m_last + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) m_valid[i] <= 1'b0;
      m_busy <= 0;
      m_last <= 3;
      m_slot <= 0;
      m_lat  <= 0;
    end else if (downloading) begin
      for (int i = 0; i < 4; i++) m_valid[i] <= 1'b0;
      if (m_busy == 1 || (m_busy == 2 && bus.data_rdy)) m_busy <= 0;
    end else begin
      case (m_busy)
        0: if (m_pick() >= 0) begin
          m_slot <= m_pick();
          m_last <= m_pick();
          m_lat  <= s_addr(m_pick()) >> 2;
          m_busy <= 1;
        end
        1: if (bus.sdram_ack) m_busy <= 2;
        default: if (bus.data_rdy) begin
          m_data[m_slot]  <= bus.data_read;
          m_line[m_slot]  <= m_lat;
          m_valid[m_slot] <= 1'b1;
          m_busy <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    bit any_miss;
    bit e_ok;
    any_miss = 1'b0;
    for (int s = 0; s < 4; s++) begin
      any_miss = any_miss | m_miss(s);
      e_ok = rstn && !downloading && m_hit(s);
      chk($sformatf("cyc_ok%0d", s), 32'(s_out(s)[8]), 32'(e_ok));
      chk($sformatf("cyc_dout%0d", s), 32'(s_out(s)[7:0]),
          e_ok ? ((m_data[s] >> (8 * (s_addr(s) & 3))) & 32'hFF) : 32'h0);
    end
    chk("cyc_req", 32'(bus.sdram_req), 32'(rstn && m_busy == 1));
    if (rstn && m_busy == 1)
      chk("cyc_addr", 32'(bus.sdram_addr), (s_off(m_slot) + 2 * m_lat) & 32'h3FFFFF);
    chk("cyc_refresh", 32'(bus.refresh_en), 32'(rstn && ((m_busy == 0 && !any_miss) || downloading)));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic serve(input logic [31:0] d);
    int n;
    n = 0;
    while (!bus.sdram_req && n < 20) begin
      step();
      n++;
    end
    chk("serve_req_seen", 32'(bus.sdram_req), 32'd1);
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b1;
    bus.data_read = d;
    step();
    bus.data_rdy  = 1'b0;
  endtask

  initial begin
    bus.slot0_cs = 0; bus.slot0_addr = '0;
    bus.slot1_cs = 0; bus.slot1_addr = '0;
    bus.slot2_cs = 0; bus.slot2_addr = '0;
    bus.slot3_cs = 0; bus.slot3_addr = '0;
    bus.sdram_ack = 0; bus.data_rdy = 0; bus.data_read = '0;
    repeat (3) step();
    chk("rst_req", 32'(bus.sdram_req), 32'd0);
    chk("rst_refresh", 32'(bus.refresh_en), 32'd0);
    chk("rst_addr", 32'(bus.sdram_addr), 32'd0);
    rstn = 1'b1;
    step();
    chk("idle_refresh", 32'(bus.refresh_en), 32'd1);
    bus.data_rdy = 1'b1; step(); bus.data_rdy = 1'b0;
    bus.sdram_ack = 1'b1; step(); bus.sdram_ack = 1'b0;
    step();
    chk("stray_req", 32'(bus.sdram_req), 32'd0);

    bus.slot0_cs = 1'b1; bus.slot0_addr = 18'h00005;
    #1;
    chk("miss_refresh", 32'(bus.refresh_en), 32'd0);
    chk("miss_ok0", 32'(bus.slot0_ok), 32'd0);
    step();
    chk("t1_req", 32'(bus.sdram_req), 32'd1);
    chk("t1_addr", 32'(bus.sdram_addr), 32'h000002);
    serve(32'h44332211);
    chk("t1_ok", 32'(bus.slot0_ok), 32'd1);
    chk("t1_dout", 32'(bus.slot0_dout), 32'h22);
    bus.slot0_addr = 18'h00006;
    #1;
    chk("hit_ok", 32'(bus.slot0_ok), 32'd1);
    chk("hit_dout", 32'(bus.slot0_dout), 32'h33);
    chk("hit_req", 32'(bus.sdram_req), 32'd0);
    step();

    bus.slot1_cs = 1'b1; bus.slot1_addr = 15'h0008;
    step();
    chk("s1_addr", 32'(bus.sdram_addr), 32'h014004);
    serve(32'hA1B2C3D4);
    chk("s1_dout", 32'(bus.slot1_dout), 32'hD4);

    bus.slot1_cs = 1'b0;
    rstn = 1'b0; step(); rstn = 1'b1;
    bus.slot0_addr = 18'h00100;
    bus.slot2_cs = 1'b1; bus.slot2_addr = 12'h010;
    step();
    chk("rr_addr0", 32'(bus.sdram_addr), 32'h000080);
    serve(32'h11111111);
    step();
    chk("rr_addr2", 32'(bus.sdram_addr), 32'h020008);
    bus.sdram_ack = 1'b1; step(); bus.sdram_ack = 1'b0;
    bus.slot0_addr = 18'h00200;
    step();
    chk("wait_refresh", 32'(bus.refresh_en), 32'd0);
    bus.data_rdy = 1'b1; bus.data_read = 32'h22222222;
    bus.slot3_cs = 1'b1; bus.slot3_addr = 15'h0004;
    step();
    bus.data_rdy = 1'b0;
    chk("rr_ok2", 32'(bus.slot2_ok), 32'd1);
    step();
    chk("rr_addr3_wrap", 32'(bus.sdram_addr), 32'h000001);
    serve(32'h33333333);
    step();
    chk("rr_addr0b", 32'(bus.sdram_addr), 32'h000100);
    serve(32'h44444444);
    chk("rr_dout0b", 32'(bus.slot0_dout), 32'h44);

    bus.slot0_cs = 1'b0; bus.slot2_cs = 1'b0; bus.slot3_cs = 1'b0;
    bus.slot1_cs = 1'b1; bus.slot1_addr = 15'h0040;
    step();
    chk("dl_addr", 32'(bus.sdram_addr), 32'h014020);
    bus.sdram_ack = 1'b1; step(); bus.sdram_ack = 1'b0;
    bus.slot0_cs = 1'b1;
    #1;
    chk("pre_dl_ok0", 32'(bus.slot0_ok), 32'd1);
    downloading = 1'b1;
    #1;
    chk("dl_ok0", 32'(bus.slot0_ok), 32'd0);
    chk("dl_req", 32'(bus.sdram_req), 32'd0);
    chk("dl_refresh", 32'(bus.refresh_en), 32'd1);
    bus.slot0_cs = 1'b0;
    step();
    bus.data_rdy = 1'b1; bus.data_read = 32'hDEADBEEF; step(); bus.data_rdy = 1'b0;
    step();
    chk("dl_noreq", 32'(bus.sdram_req), 32'd0);
    downloading = 1'b0;
    step();
    chk("re_req", 32'(bus.sdram_req), 32'd1);
    chk("re_addr", 32'(bus.sdram_addr), 32'h014020);
    serve(32'h55667788);
    chk("re_dout1", 32'(bus.slot1_dout), 32'h88);

    bus.slot1_addr = 15'h0080;
    step();
    chk("dlr_req", 32'(bus.sdram_req), 32'd1);
    downloading = 1'b1;
    step();
    chk("dlr_drop", 32'(bus.sdram_req), 32'd0);
    downloading = 1'b0;
    step();
    chk("dlr_regrant", 32'(bus.sdram_req), 32'd1);
    serve(32'h0A0B0C0D);
    chk("dlr_dout1", 32'(bus.slot1_dout), 32'h0D);

    bus.slot2_cs = 1'b1; bus.slot2_addr = 12'h020;
    step();
    bus.sdram_ack = 1'b1; step(); bus.sdram_ack = 1'b0;
    chk("busy_hit_ok1", 32'(bus.slot1_ok), 32'd1);
    rstn = 1'b0;
    #1;
    chk("ar_req", 32'(bus.sdram_req), 32'd0);
    chk("ar_ok1", 32'(bus.slot1_ok), 32'd0);
    chk("ar_dout1", 32'(bus.slot1_dout), 32'd0);
    chk("ar_refresh", 32'(bus.refresh_en), 32'd0);
    chk("ar_addr", 32'(bus.sdram_addr), 32'd0);
    step();
    rstn = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
